// File: rtl/tone_sequencer.sv
// Plays one handshaked note (tune/duration/volume) as a PWM tone, then a silent gap, then pulses note_done.
// Accepts only in IDLE with stop low; pwm_out is registered, so the first high cycle is the first PLAY cycle.
module tone_sequencer #(
    parameter int CNT_W     = 20,
    parameter int OCTAVES   = 3,
    parameter int VOL_W     = 4,
    parameter int DUR_W     = 8,
    parameter int TICK_CYC  = 50000,
    parameter int GAP_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_tune,
    input  logic [DUR_W-1:0] in_dur,
    input  logic [VOL_W-1:0] in_vol,
    input  logic             stop,
    output logic             pwm_out,
    output logic             busy,
    output logic             note_done
);
    localparam int TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int PROD_W = CNT_W + VOL_W;
    localparam logic [TICK_W-1:0] TICK_END = TICK_W'(TICK_CYC - 1);
    localparam logic [DUR_W-1:0]  GAP_END  = DUR_W'(GAP_TICKS);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t             state_q, state_d;
    logic               audible_q, audible_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [CNT_W-1:0]   pc_q, pc_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [DUR_W-1:0]   dcnt_q, dcnt_d;
    logic               pwm_q, pwm_d;
    logic               done_q, done_d;

    logic [3:0]         note, oct;
    logic               audible_in;
    logic [CNT_W-1:0]   base, period_in, high_in;
    logic [PROD_W-1:0]  prod;

    // Decode the offered note so period/high_cnt can be registered on the accept edge.
    always_comb begin
        note       = in_tune[3:0];
        oct        = in_tune[7:4];
        audible_in = (note >= 4'd1) && (note <= 4'd7) && (oct >= 4'd1) && (int'(oct) <= OCTAVES);
        case (note)
            4'd1:    base = CNT_W'(18'h2EA9B);
            4'd2:    base = CNT_W'(18'h29902);
            4'd3:    base = CNT_W'(18'h25093);
            4'd4:    base = CNT_W'(18'h22F50);
            4'd5:    base = CNT_W'(18'h1F23F);
            4'd6:    base = CNT_W'(18'h1BBE4);
            4'd7:    base = CNT_W'(18'h18B73);
            default: base = '0;
        endcase
        period_in = audible_in ? (base >> (oct - 4'd1)) : '0;
        prod      = PROD_W'(period_in) * PROD_W'(in_vol);
        high_in   = CNT_W'(prod >> (VOL_W + 1));
    end

    assign in_ready  = (state_q == S_IDLE) && !stop;
    assign busy      = (state_q != S_IDLE);
    assign pwm_out   = pwm_q;
    assign note_done = done_q;

    always_comb begin
        state_d   = state_q;
        audible_d = audible_q;
        period_d  = period_q;
        high_d    = high_q;
        dur_d     = dur_q;
        pc_d      = pc_q;
        tick_d    = tick_q;
        dcnt_d    = dcnt_q;
        pwm_d     = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    audible_d = audible_in;
                    period_d  = period_in;
                    high_d    = high_in;
                    dur_d     = in_dur;
                    pc_d      = '0;
                    tick_d    = '0;
                    dcnt_d    = '0;
                    if (in_dur == '0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_PLAY;
                        pwm_d   = audible_in && (high_in != '0);
                    end
                end
            end
            S_PLAY: begin
                if (!audible_q || pc_q == period_q - 1'b1) pc_d = '0;
                else                                       pc_d = pc_q + 1'b1;
                if (tick_q == TICK_END) begin
                    tick_d = '0;
                    dcnt_d = dcnt_q + 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
                // A partial final period is cut short: leave as soon as the last tick ends.
                if (tick_q == TICK_END && dcnt_q + 1'b1 == dur_q) begin
                    state_d = S_GAP;
                    dcnt_d  = '0;
                    pc_d    = '0;
                end else begin
                    pwm_d = audible_q && (pc_d < high_q);
                end
            end
            S_GAP: begin
                if (tick_q == TICK_END) begin
                    tick_d = '0;
                    if (dcnt_q + 1'b1 == GAP_END) begin
                        state_d = S_IDLE;
                        dcnt_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (stop) begin
            state_d = S_IDLE;
            pwm_d   = 1'b0;
            done_d  = 1'b0;
            pc_d    = '0;
            tick_d  = '0;
            dcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            audible_q <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            dur_q     <= '0;
            pc_q      <= '0;
            tick_q    <= '0;
            dcnt_q    <= '0;
            pwm_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            audible_q <= audible_d;
            period_q  <= period_d;
            high_q    <= high_d;
            dur_q     <= dur_d;
            pc_q      <= pc_d;
            tick_q    <= tick_d;
            dcnt_q    <= dcnt_d;
            pwm_q     <= pwm_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: note table plus hand-written stop/reset/held-valid sequences.
module tb_tone_sequencer;
    localparam int T = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_tune;
    logic [7:0] in_dur;
    logic [3:0] in_vol;
    logic       stop;
    logic       pwm_out;
    logic       busy;
    logic       note_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tone_sequencer #(
        .CNT_W(20), .OCTAVES(3), .VOL_W(4), .DUR_W(8), .TICK_CYC(T), .GAP_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_tune(in_tune), .in_dur(in_dur), .in_vol(in_vol), .stop(stop),
        .pwm_out(pwm_out), .busy(busy), .note_done(note_done)
    );

    typedef struct {
        logic [7:0] tune;
        logic [7:0] dur;
        logic [3:0] vol;
        int         hi_run;
        int         hi_total;
        int         rise_gap;
        int         done_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_note(input logic [7:0] t, input logic [7:0] d, input logic [3:0] v);
        int w = 0;
        while (!in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_send", int'(in_ready), 1);
        in_tune  = t;
        in_dur   = d;
        in_vol   = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_tune  = 8'h17;
        in_dur   = 8'hFF;
        in_vol   = 4'hF;
    endtask

    // Cycle k is the k-th cycle after the accept edge; done_lat counts edges to note_done.
    task automatic observe(input int limit, output int hi_run, output int hi_total,
                           output int first_rise, output int rise_gap, output int done_lat,
                           output int busy1, output int ready_hi);
        bit prev = 1'b0;
        bit fell = 1'b0;
        int rises = 0;
        hi_run = 0; hi_total = 0; first_rise = 0; rise_gap = 0;
        done_lat = -1; busy1 = 0; ready_hi = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = int'(busy);
            if (pwm_out) begin
                hi_total++;
                if (!prev) begin
                    rises++;
                    if (rises == 1) first_rise = k;
                    else if (rises == 2) rise_gap = k - first_rise;
                end
                if (rises == 1 && !fell) hi_run++;
            end else if (prev) begin
                fell = 1'b1;
            end
            prev = pwm_out;
            if (note_done) begin
                done_lat = k - 1;
                break;
            end
            if (in_ready) ready_hi++;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hr, ht, fr, rg, dl, b1, rh, cnt_done, cnt_busy;
        rst = 1'b1; in_valid = 1'b0; stop = 1'b0;
        in_tune = 8'h00; in_dur = 8'h00; in_vol = 4'h0;

        //          tune   dur  vol  hi_run  hi_total rise_gap done_lat
        vecs[0]  = '{8'h31, 240, 15, 22397, 22615, 47782, 48400};
        vecs[1]  = '{8'h00,   3, 15,     0,     0,     0,  1000};
        vecs[2]  = '{8'h18,   3, 15,     0,     0,     0,  1000};
        vecs[3]  = '{8'h41,   3, 15,     0,     0,     0,  1000};
        vecs[4]  = '{8'h37,   1,  8,   200,   200,     0,   600};
        vecs[5]  = '{8'h37,   5,  1,   790,   790,     0,  1400};
        vecs[6]  = '{8'h25,  12,  1,  1992,  1992,     0,  2800};
        vecs[7]  = '{8'h22,  14,  1,  2660,  2660,     0,  3200};
        vecs[8]  = '{8'h36,  10,  2,  1775,  1775,     0,  2400};
        vecs[9]  = '{8'h34,   6,  1,  1118,  1118,     0,  1600};
        vecs[10] = '{8'h31,   2,  0,     0,     0,     0,   800};
        vecs[11] = '{8'h31,   0, 15,     0,     0,     0,   400};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_ready", int'(in_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(note_done), 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            send_note(vecs[i].tune, vecs[i].dur, vecs[i].vol);
            observe(vecs[i].done_lat + 100, hr, ht, fr, rg, dl, b1, rh);
            $display("vector %0d tune %h dur %0d vol %0d", i, vecs[i].tune, vecs[i].dur, vecs[i].vol);
            check("hi_run", hr, vecs[i].hi_run);
            check("hi_total", ht, vecs[i].hi_total);
            check("first_rise", fr, (vecs[i].hi_total > 0) ? 1 : 0);
            check("rise_gap", rg, vecs[i].rise_gap);
            check("done_lat", dl, vecs[i].done_lat);
            check("busy_after_accept", b1, 1);
            check("ready_low_while_busy", rh, 0);
        end

        // Held request during a note: no restart, then taken in the note_done cycle.
        @(negedge clk);
        in_tune = 8'h11; in_dur = 8'd2; in_vol = 4'd15; in_valid = 1'b1;
        @(posedge clk);
        #1;
        observe(1000, hr, ht, fr, rg, dl, b1, rh);
        check("held_ready_low", rh, 0);
        check("held_done_lat", dl, 800);
        check("held_hi_total", ht, 400);
        check("held_ready_at_done", int'(in_ready), 1);
        @(negedge clk);
        check("held_reaccept_busy", int'(busy), 1);
        check("held_reaccept_pwm", int'(pwm_out), 1);
        in_valid = 1'b0;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        check("held_stop_busy", int'(busy), 0);

        // Stop in tick 4 of a 10-tick note.
        send_note(8'h31, 8'd10, 4'd15);
        repeat (4 * T + 50) @(negedge clk);
        check("stop_pre_pwm", int'(pwm_out), 1);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        check("stop_busy", int'(busy), 0);
        check("stop_pwm", int'(pwm_out), 0);
        check("stop_ready", int'(in_ready), 1);
        cnt_done = 0;
        repeat (2000) begin
            @(negedge clk);
            if (note_done) cnt_done++;
        end
        check("stop_no_done", cnt_done, 0);

        // Stop together with a request in IDLE: nothing accepted.
        stop = 1'b1; in_valid = 1'b1; in_tune = 8'h31; in_dur = 8'd1; in_vol = 4'd15;
        @(posedge clk);
        #1;
        stop = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("stop_valid_busy", int'(busy), 0);

        // Asynchronous reset mid-PLAY.
        send_note(8'h31, 8'd10, 4'd15);
        repeat (300) @(negedge clk);
        check("rst_pre_pwm", int'(pwm_out), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        cnt_done = 0;
        cnt_busy = 0;
        repeat (2600) begin
            @(negedge clk);
            if (note_done) cnt_done++;
            if (busy) cnt_busy++;
        end
        check("rst_no_done", cnt_done, 0);
        check("rst_stays_idle", cnt_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
